// File: rtl/rf_wr_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: FSM states and MDU FIFO entry.
package rf_wr_port_arbiter_pkg;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_NREGS  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } rf_arb_state_t;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } rf_arb_entry_t;
endpackage

// File: rtl/rf_wr_port_arbiter_fifo.sv
// Circular buffer holding MDU results until a write-port slot is free.
// Pointers carry an extra wrap bit so a full buffer differs from an empty one.
module rf_arb_fifo
  import rf_wr_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  rf_arb_entry_t             push_entry_i,
  input  logic                      pop_i,
  output rf_arb_entry_t             head_o,
  output logic [$clog2(DEPTH):0]    count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  rf_arb_entry_t r_mem [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (pop_i)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr[AW-1:0]] <= push_entry_i;
  end

  assign head_o  = r_mem[r_rd_ptr[AW-1:0]];
  assign count_o = r_wr_ptr - r_rd_ptr;
endmodule

// File: rtl/rf_wr_port_arbiter.sv
// Shares the RF write port between writeback and queued MDU results, with starvation drain
// and a pending-rd scoreboard. Define RF_ARB_PERF_EN to add stall/drain performance counters.
module rf_wr_port_arbiter
  import rf_wr_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wb_req_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  input  logic        mdu_issue_i,
  input  logic [4:0]  mdu_issue_rd_i,
  input  logic        mdu_valid_i,
  output logic        mdu_ready_o,
  input  logic [4:0]  mdu_rd_i,
  input  logic [31:0] mdu_data_i,
  output logic        rf_wr_en_o,
  output logic [4:0]  rf_wr_reg_o,
  output logic [31:0] rf_wr_data_o,
  output logic        stall_o,
  output logic [31:0] pending_o
`ifdef RF_ARB_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_drain_cnt_o
`endif
);
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);
  localparam logic [AGE_W-1:0] AGE_ONE = 1;

  rf_arb_state_t    r_state;
  logic             r_stall;
  logic [AGE_W-1:0] r_age;
  logic [31:0]      r_pending;

  logic [CW-1:0]    w_count;
  logic [CW-1:0]    w_count_nxt;
  rf_arb_entry_t    w_head;
  rf_arb_entry_t    w_push_entry;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_drain;
  logic             w_wb_grant;
  logic             w_age_hit;
  logic [31:0]      w_pending_nxt;

  assign w_empty      = (w_count == '0);
  assign w_full       = (w_count == CW'(DEPTH));
  assign mdu_ready_o  = !w_full;
  assign w_push       = mdu_valid_i && mdu_ready_o && (mdu_rd_i != '0);
  assign w_push_entry = '{rd: mdu_rd_i, data: mdu_data_i};
  assign w_count_nxt  = w_count + CW'(w_push) - CW'(w_drain);
  assign w_age_hit    = (int'(r_age) + 1) >= int'(STARVE_LIMIT);

  rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (w_push),
    .push_entry_i(w_push_entry),
    .pop_i       (w_drain),
    .head_o      (w_head),
    .count_o     (w_count)
  );

  // Grant: forced drain beats WB; a WB write to x0 is treated as an idle slot.
  always_comb begin
    w_drain      = 1'b0;
    w_wb_grant   = 1'b0;
    rf_wr_en_o   = 1'b0;
    rf_wr_reg_o  = '0;
    rf_wr_data_o = '0;
    if (r_state == FORCE)                     w_drain    = !w_empty;
    else if (wb_req_i && (wb_rd_i != '0))     w_wb_grant = 1'b1;
    else                                      w_drain    = !w_empty;
    if (w_drain) begin
      rf_wr_en_o   = 1'b1;
      rf_wr_reg_o  = w_head.rd;
      rf_wr_data_o = w_head.data;
    end else if (w_wb_grant) begin
      rf_wr_en_o   = 1'b1;
      rf_wr_reg_o  = wb_rd_i;
      rf_wr_data_o = wb_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_stall <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_push) r_state <= PEND;
          r_stall <= 1'b0;
        end
        PEND: begin
          r_stall <= 1'b0;
          if (w_drain) begin
            if (w_count_nxt == '0) r_state <= IDLE;
          end else if (w_age_hit || w_full) begin
            r_state <= FORCE;
            r_stall <= 1'b1;
          end
        end
        FORCE: begin
          r_state <= (w_count_nxt != '0) ? PEND : IDLE;
          r_stall <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign stall_o = r_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                r_age <= '0;
    else if (w_drain || (r_state == IDLE))      r_age <= '0;
    else if (!w_empty && (r_age != AGE_MAX))    r_age <= r_age + AGE_ONE;
  end

  // A new issue to the same rd outlives the drain of its older result.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_drain) w_pending_nxt[w_head.rd] = 1'b0;
    if (mdu_issue_i && (mdu_issue_rd_i != '0)) w_pending_nxt[mdu_issue_rd_i] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_pending <= '0;
    else         r_pending <= w_pending_nxt;
  end

  assign pending_o = r_pending;

`ifdef RF_ARB_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_drain_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_stall_cnt <= '0;
      r_perf_drain_cnt <= '0;
    end else begin
      r_perf_stall_cnt <= r_perf_stall_cnt + 32'(r_state == FORCE);
      r_perf_drain_cnt <= r_perf_drain_cnt + 32'(w_drain);
    end
  end

  assign perf_stall_cnt_o = r_perf_stall_cnt;
  assign perf_drain_cnt_o = r_perf_drain_cnt;
`endif

`ifndef SYNTHESIS
  a_no_waw: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_wb_grant && r_pending[wb_rd_i]));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_push && w_full));
  a_no_force_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !((r_state == FORCE) && w_empty));
`endif
endmodule

// File: tb/tb_rf_wr_port_arbiter.sv
// Bench for rf_wr_port_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_rf_wr_port_arbiter;
  localparam int DEPTH = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        wb_req_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        mdu_issue_i;
  logic [4:0]  mdu_issue_rd_i;
  logic        mdu_valid_i;
  logic        mdu_ready_o;
  logic [4:0]  mdu_rd_i;
  logic [31:0] mdu_data_i;
  logic        rf_wr_en_o;
  logic [4:0]  rf_wr_reg_o;
  logic [31:0] rf_wr_data_o;
  logic        stall_o;
  logic [31:0] pending_o;
`ifdef RF_ARB_PERF_EN
  logic [31:0] perf_stall_cnt_o;
  logic [31:0] perf_drain_cnt_o;
`endif

  rf_wr_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .wb_req_i      (wb_req_i),
    .wb_rd_i       (wb_rd_i),
    .wb_data_i     (wb_data_i),
    .mdu_issue_i   (mdu_issue_i),
    .mdu_issue_rd_i(mdu_issue_rd_i),
    .mdu_valid_i   (mdu_valid_i),
    .mdu_ready_o   (mdu_ready_o),
    .mdu_rd_i      (mdu_rd_i),
    .mdu_data_i    (mdu_data_i),
    .rf_wr_en_o    (rf_wr_en_o),
    .rf_wr_reg_o   (rf_wr_reg_o),
    .rf_wr_data_o  (rf_wr_data_o),
    .stall_o       (stall_o),
    .pending_o     (pending_o)
`ifdef RF_ARB_PERF_EN
    ,
    .perf_stall_cnt_o(perf_stall_cnt_o),
    .perf_drain_cnt_o(perf_drain_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Model: results waiting in arrival order, cycles the oldest has waited, forced-drain flag.
  ent_t        mq[$];
  int          m_age;
  bit          m_force;
  logic [31:0] m_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_age   = 0;
    m_force = 0;
    m_pend  = '0;
  endtask

  task automatic idle_inputs();
    wb_req_i = 0; wb_rd_i = 0; wb_data_i = 0;
    mdu_issue_i = 0; mdu_issue_rd_i = 0;
    mdu_valid_i = 0; mdu_rd_i = 0; mdu_data_i = 0;
  endtask

  // Compare this cycle's outputs with the model, advance the model, move to just after the edge.
  task automatic tick();
    int          sz;
    bit          drain, push, ready;
    logic        e_en;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    @(negedge clk);
    sz    = mq.size();
    ready = (sz < DEPTH);
    drain = 0; e_en = 0; e_reg = 0; e_data = 0;
    if (m_force) drain = (sz > 0);
    else if (wb_req_i && wb_rd_i != 0) begin
      e_en = 1; e_reg = wb_rd_i; e_data = wb_data_i;
    end else drain = (sz > 0);
    if (drain) begin
      e_en = 1; e_reg = mq[0].rd; e_data = mq[0].data;
    end
    chk("wr_en",   32'(rf_wr_en_o), 32'(e_en));
    chk("wr_reg",  32'(rf_wr_reg_o), 32'(e_reg));
    chk("wr_data", rf_wr_data_o, e_data);
    chk("stall",   32'(stall_o), 32'(m_force));
    chk("ready",   32'(mdu_ready_o), 32'(ready));
    chk("pending", pending_o, m_pend);
    if (!rst_ni) model_reset();
    else begin
      push = mdu_valid_i && ready && (mdu_rd_i != 0);
      if (drain) m_pend[mq[0].rd] = 1'b0;
      if (mdu_issue_i && mdu_issue_rd_i != 0) m_pend[mdu_issue_rd_i] = 1'b1;
      m_pend[0] = 1'b0;
      if (m_force) m_force = 0;
      else if (!drain && sz > 0 && (m_age + 1 >= STARVE_LIMIT || sz == DEPTH)) m_force = 1;
      if (drain || sz == 0) m_age = 0;
      else if (m_age < STARVE_LIMIT) m_age++;
      if (drain) void'(mq.pop_front());
      if (push) mq.push_back('{rd: mdu_rd_i, data: mdu_data_i});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [4:0] rd, input logic [31:0] data);
    mdu_valid_i = 1; mdu_rd_i = rd; mdu_data_i = data;
    tick();
    mdu_valid_i = 0; mdu_rd_i = 0; mdu_data_i = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    model_reset();
    rst_ni = 0;
    #1;
    chk("rst_ready",   32'(mdu_ready_o), 32'd1);
    chk("rst_stall",   32'(stall_o), 32'd0);
    chk("rst_pending", pending_o, 32'd0);
    chk("rst_wr_en",   32'(rf_wr_en_o), 32'd0);
    tick(); tick();
    rst_ni = 1;
    tick();

    // 1: single result drains in the next idle slot and clears its pending bit
    mdu_issue_i = 1; mdu_issue_rd_i = 5;
    tick();
    mdu_issue_i = 0; mdu_issue_rd_i = 0;
    chk("t1_pend_set", 32'(pending_o[5]), 32'd1);
    push_one(5'd5, 32'hDEAD);
    chk("t1_en",   32'(rf_wr_en_o), 32'd1);
    chk("t1_reg",  32'(rf_wr_reg_o), 32'd5);
    chk("t1_data", rf_wr_data_o, 32'hDEAD);
    tick();
    chk("t1_pend_clr", 32'(pending_o[5]), 32'd0);

    // 4: rd=0 on either side produces no write
    mdu_valid_i = 1; mdu_rd_i = 0; mdu_data_i = 32'h1234;
    wb_req_i = 1; wb_rd_i = 0; wb_data_i = 32'h5555;
    #1;
    chk("t4_wb_x0_en", 32'(rf_wr_en_o), 32'd0);
    tick();
    idle_inputs();
    chk("t4_no_entry_en", 32'(rf_wr_en_o), 32'd0);
    tick();

    // 2: starvation under continuous WB traffic forces one drain cycle
    wb_req_i = 1; wb_rd_i = 3; wb_data_i = 32'hAAAA0003;
    push_one(5'd9, 32'h0909);
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      chk("t2_wait_stall", 32'(stall_o), 32'd0);
      chk("t2_wait_reg",   32'(rf_wr_reg_o), 32'd3);
      tick();
    end
    chk("t2_force_stall", 32'(stall_o), 32'd1);
    chk("t2_force_reg",   32'(rf_wr_reg_o), 32'd9);
    chk("t2_force_data",  rf_wr_data_o, 32'h0909);
    tick();
    chk("t2_after_stall", 32'(stall_o), 32'd0);
    chk("t2_after_reg",   32'(rf_wr_reg_o), 32'd3);

    // 3: full FIFO forces a drain, ready returns one cycle later
    for (int i = 0; i < DEPTH; i++) begin
      chk("t3_ready_fill", 32'(mdu_ready_o), 32'd1);
      push_one(5'(10 + i), 32'(32'h100 + i));
    end
    chk("t3_ready_full", 32'(mdu_ready_o), 32'd0);
    chk("t3_stall_full", 32'(stall_o), 32'd0);
    tick();
    chk("t3_force_stall", 32'(stall_o), 32'd1);
    chk("t3_force_reg",   32'(rf_wr_reg_o), 32'd10);
    chk("t3_force_ready", 32'(mdu_ready_o), 32'd0);
    tick();
    chk("t3_ready_back", 32'(mdu_ready_o), 32'd1);
    chk("t3_stall_back", 32'(stall_o), 32'd0);
    idle_inputs();
    repeat (4) tick();

    // 5: issue and drain of the same rd in one cycle keeps it pending
    push_one(5'd7, 32'h0707);
    mdu_issue_i = 1; mdu_issue_rd_i = 7;
    chk("t5_drain_reg", 32'(rf_wr_reg_o), 32'd7);
    tick();
    idle_inputs();
    chk("t5_pend_kept", 32'(pending_o[7]), 32'd1);

    // 6: reset during a forced drain discards everything
    wb_req_i = 1; wb_rd_i = 3; wb_data_i = 32'h33;
    for (int i = 0; i < DEPTH; i++) push_one(5'(20 + i), 32'(32'h200 + i));
    tick();
    chk("t6_pre_stall", 32'(stall_o), 32'd1);
    rst_ni = 0;
    idle_inputs();
    #1;
    chk("t6_rst_stall",   32'(stall_o), 32'd0);
    chk("t6_rst_en",      32'(rf_wr_en_o), 32'd0);
    chk("t6_rst_reg",     32'(rf_wr_reg_o), 32'd0);
    chk("t6_rst_data",    rf_wr_data_o, 32'd0);
    chk("t6_rst_ready",   32'(mdu_ready_o), 32'd1);
    chk("t6_rst_pending", pending_o, 32'd0);
    model_reset();
    tick(); tick();
    rst_ni = 1;
    repeat (5) begin
      chk("t6_no_ghost", 32'(rf_wr_en_o), 32'd0);
      tick();
    end

    // Random traffic, alternating light and heavy WB load
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int unsigned wb_pct;
      logic [4:0]  r;
      wb_pct = ((cyc / 60) % 2 == 0) ? 30 : 95;
      r = 5'($urandom_range(0, 31));
      if (m_pend[r]) r = 0;
      wb_req_i       = ($urandom_range(0, 99) < wb_pct);
      wb_rd_i        = r;
      wb_data_i      = $urandom;
      mdu_issue_i    = ($urandom_range(0, 99) < 15);
      mdu_issue_rd_i = 5'($urandom_range(0, 31));
      mdu_valid_i    = ($urandom_range(0, 99) < 35);
      mdu_rd_i       = 5'($urandom_range(0, 31));
      mdu_data_i     = $urandom;
      tick();
    end
    idle_inputs();
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
